// File: rtl/grey_histogram.sv
// grey_histogram
// Per-frame histogram of greyscale samples. Each accepted sample is binned by
// its top BIN_BITS bits into an on-chip count memory. The finished histogram
// is held for random-access readout until acknowledged, then a clear sweep
// re-zeroes the memory for the next frame.
//
// Build option: define HIST_SATURATE_EN to make bin counters stick at all-ones
// instead of wrapping modulo 2^COUNT_WIDTH.
module grey_histogram #(
    parameter int NUM_BITS_GREY = 12,
    parameter int BIN_BITS      = 8,
    parameter int COUNT_WIDTH   = 20
) (
    input  logic                     iclk,
    input  logic                     irst_n,
    input  logic [NUM_BITS_GREY-1:0] igrey,
    input  logic                     igrey_val,
    input  logic                     ifrm_val,
    input  logic                     iread_en,
    input  logic [BIN_BITS-1:0]      iread_addr,
    input  logic                     iack,
    output logic [COUNT_WIDTH-1:0]   oread_data,
    output logic                     oread_val,
    output logic                     ohist_ready,
    output logic                     obusy,
    output logic                     ofrm_drop
);

    localparam int                     NUM_BINS  = 1 << BIN_BITS;
    localparam logic [BIN_BITS-1:0]    LAST_BIN  = '1;
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

    typedef enum logic [2:0] {
        S_CLEAR = 3'd0,
        S_WAIT  = 3'd1,
        S_ACCUM = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    logic [BIN_BITS-1:0]     r_clr_addr;
    logic                    r_flush_cnt;
    logic                    r_frm_prev;
    logic                    r_frm_drop;

    logic [COUNT_WIDTH-1:0]  r_mem [NUM_BINS];

    logic                    r_s1_val;
    logic [BIN_BITS-1:0]     r_s1_addr;
    logic [COUNT_WIDTH-1:0]  r_s1_rdata;
    logic [COUNT_WIDTH-1:0]  w_s2_wdata;

    logic [COUNT_WIDTH-1:0]  r_read_data;
    logic                    r_read_val;

    logic [BIN_BITS-1:0]     w_bin;
    logic                    w_frm_rise;
    logic                    w_accept;
    logic                    w_fwd;
    logic                    w_read_go;
    logic                    w_clr_we;
    logic                    w_drop;

    // The bin is simply the most significant BIN_BITS of the grey sample.
    assign w_bin      = igrey[NUM_BITS_GREY-1 -: BIN_BITS];
    assign w_frm_rise = ifrm_val & ~r_frm_prev;

    // A new sample hitting the bin that stage 2 is writing right now must see
    // the value being written, not the stale memory word.
    assign w_fwd = r_s1_val && (r_s1_addr == w_bin);

`ifdef HIST_SATURATE_EN
    assign w_s2_wdata = (r_s1_rdata == COUNT_MAX) ? COUNT_MAX : (r_s1_rdata + COUNT_ONE);
`else
    assign w_s2_wdata = r_s1_rdata + COUNT_ONE;
`endif

    // Next-state decode plus the per-state strobes that steer the datapath.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_read_go    = 1'b0;
        w_clr_we     = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_clr_we = 1'b1;
                w_drop   = w_frm_rise;
                if (r_clr_addr == LAST_BIN) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_frm_rise) begin
                    w_accept     = igrey_val;
                    w_next_state = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (!ifrm_val) begin
                    w_next_state = S_FLUSH;
                end else begin
                    w_accept = igrey_val;
                end
            end
            S_FLUSH: begin
                w_drop = w_frm_rise;
                if (r_flush_cnt) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_drop = w_frm_rise;
                if (iack) begin
                    w_next_state = S_CLEAR;
                end else begin
                    w_read_go = iread_en;
                end
            end
            default: begin
                w_next_state = S_CLEAR;
            end
        endcase
    end

    // State register; any reset sends the block back through a full clear.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Clear-sweep address, flush timer, frame edge history and drop pulse.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_clr_addr  <= '0;
            r_flush_cnt <= 1'b0;
            r_frm_prev  <= 1'b0;
            r_frm_drop  <= 1'b0;
        end else begin
            r_clr_addr  <= (r_state == S_CLEAR) ? (r_clr_addr + 1'b1) : '0;
            r_flush_cnt <= (r_state == S_FLUSH) ? ~r_flush_cnt : 1'b0;
            r_frm_prev  <= ifrm_val;
            r_frm_drop  <= w_drop;
        end
    end

    // Stage 1: latch the bin and fetch its current count (or the forwarded one).
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_s1_val   <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_rdata <= '0;
        end else begin
            r_s1_val <= w_accept;
            if (w_accept) begin
                r_s1_addr  <= w_bin;
                r_s1_rdata <= w_fwd ? w_s2_wdata : r_mem[w_bin];
            end
        end
    end

    // Single write port: clear sweep zeroes bins, otherwise stage 2 writes back.
    always_ff @(posedge iclk) begin
        if (w_clr_we) begin
            r_mem[r_clr_addr] <= '0;
        end else if (r_s1_val) begin
            r_mem[r_s1_addr] <= w_s2_wdata;
        end
    end

    // Readout port: one-cycle latency, data holds between reads.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_read_data <= '0;
            r_read_val  <= 1'b0;
        end else begin
            r_read_val <= w_read_go;
            if (w_read_go) begin
                r_read_data <= r_mem[iread_addr];
            end
        end
    end

    assign oread_data  = r_read_data;
    assign oread_val   = r_read_val;
    assign ohist_ready = (r_state == S_DONE);
    assign obusy       = (r_state != S_DONE);
    assign ofrm_drop   = r_frm_drop;

endmodule

// File: tb/tb_grey_histogram.sv
// tb_grey_histogram
// Drives two instances from the same stimulus: a full-width one and a 4-bit
// counter one, so the narrow instance exercises wrap or saturation
// (HIST_SATURATE_EN) alongside the normal histogram.
module tb_grey_histogram;

    localparam int NBG = 12;
    localparam int BB  = 8;
    localparam int CW  = 20;
    localparam int SCW = 4;
    localparam int NB  = 1 << BB;

    logic            iclk;
    logic            irst_n;
    logic [NBG-1:0]  igrey;
    logic            igrey_val;
    logic            ifrm_val;
    logic            iread_en;
    logic [BB-1:0]   iread_addr;
    logic            iack;

    logic [CW-1:0]   oread_data;
    logic            oread_val;
    logic            ohist_ready;
    logic            obusy;
    logic            ofrm_drop;

    logic [SCW-1:0]  s_oread_data;
    logic            s_oread_val;
    logic            s_ohist_ready;
    logic            s_obusy;
    logic            s_ofrm_drop;

    int checks;
    int failures;

    int unsigned     rawHist [NB];
    logic [NBG-1:0]  frmGrey [$];
    logic            frmVal  [$];

    typedef struct {
        logic [NBG-1:0] grey;
        int             reps;
        int             expBin;
        int             expCount;
        int             zeroBin;
    } vec_t;

    vec_t vecs [4];

    grey_histogram #(
        .NUM_BITS_GREY(NBG),
        .BIN_BITS(BB),
        .COUNT_WIDTH(CW)
    ) uDut (
        .iclk(iclk),
        .irst_n(irst_n),
        .igrey(igrey),
        .igrey_val(igrey_val),
        .ifrm_val(ifrm_val),
        .iread_en(iread_en),
        .iread_addr(iread_addr),
        .iack(iack),
        .oread_data(oread_data),
        .oread_val(oread_val),
        .ohist_ready(ohist_ready),
        .obusy(obusy),
        .ofrm_drop(ofrm_drop)
    );

    grey_histogram #(
        .NUM_BITS_GREY(NBG),
        .BIN_BITS(BB),
        .COUNT_WIDTH(SCW)
    ) uNarrow (
        .iclk(iclk),
        .irst_n(irst_n),
        .igrey(igrey),
        .igrey_val(igrey_val),
        .ifrm_val(ifrm_val),
        .iread_en(iread_en),
        .iread_addr(iread_addr),
        .iack(iack),
        .oread_data(s_oread_data),
        .oread_val(s_oread_val),
        .ohist_ready(s_ohist_ready),
        .obusy(s_obusy),
        .ofrm_drop(s_ofrm_drop)
    );

    // 100 MHz clock.
    initial begin
        iclk = 1'b0;
        forever #5 iclk = ~iclk;
    end

    // Hard stop in case something never completes.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic fval, input logic gval, input logic [NBG-1:0] grey);
        ifrm_val  = fval;
        igrey_val = gval;
        igrey     = grey;
        tick();
    endtask

    task automatic pushSample(input logic [NBG-1:0] grey, input logic val);
        frmGrey.push_back(grey);
        frmVal.push_back(val);
    endtask

    task automatic clearModel();
        for (int b = 0; b < NB; b++) rawHist[b] = 0;
    endtask

    // Plays the queued frame with frame-valid high throughout, then drops it.
    // The reference model simply counts every valid sample in its bin.
    task automatic sendFrame();
        for (int i = 0; i < frmGrey.size(); i++) begin
            if (frmVal[i]) rawHist[int'(frmGrey[i] >> (NBG - BB))]++;
            applyStimulus(1'b1, frmVal[i], frmGrey[i]);
        end
        applyStimulus(1'b0, 1'b0, '0);
        frmGrey.delete();
        frmVal.delete();
    endtask

    function automatic logic [31:0] expMain(input int b);
        return 32'(rawHist[b] % (32'd1 << CW));
    endfunction

    function automatic logic [31:0] expSmall(input int b);
`ifdef HIST_SATURATE_EN
        return (rawHist[b] > 32'd15) ? 32'd15 : 32'(rawHist[b]);
`else
        return 32'(rawHist[b] % 32'd16);
`endif
    endfunction

    task automatic waitReady(input string name);
        int n;
        n = 0;
        while (!ohist_ready && n < 50) begin
            tick();
            n++;
        end
        checkOutput(name, 32'(ohist_ready), 1);
    endtask

    task automatic readOnce(input int addr, output logic [CW-1:0] d, output logic [SCW-1:0] sd);
        iread_en   = 1'b1;
        iread_addr = addr[BB-1:0];
        tick();
        checkOutput("read_val", 32'(oread_val), 1);
        d        = oread_data;
        sd       = s_oread_data;
        iread_en = 1'b0;
    endtask

    // Acknowledge the held histogram and wait out the full clear sweep.
    task automatic rearm();
        iack = 1'b1;
        tick();
        iack = 1'b0;
        checkOutput("ready_fall", 32'(ohist_ready), 0);
        clearModel();
        repeat (260) tick();
    endtask

    // Main test sequence.
    initial begin
        logic [CW-1:0]  d;
        logic [SCW-1:0] sd;
        logic [BB-1:0]  hotBins [4];
        int             len;

        vecs[0] = '{12'h000, 16,   0, 16,   1};
        vecs[1] = '{12'h800,  8, 128,  8,   0};
        vecs[2] = '{12'hFFF,  3, 255,  3, 254};
        vecs[3] = '{12'h05A,  1,   5,  1,   0};

        checks     = 0;
        failures   = 0;
        irst_n     = 1'b0;
        igrey      = '0;
        igrey_val  = 1'b0;
        ifrm_val   = 1'b0;
        iread_en   = 1'b0;
        iread_addr = '0;
        iack       = 1'b0;
        clearModel();

        repeat (3) tick();
        checkOutput("rst_data",  32'(oread_data),  0);
        checkOutput("rst_val",   32'(oread_val),   0);
        checkOutput("rst_ready", 32'(ohist_ready), 0);
        checkOutput("rst_busy",  32'(obusy),       1);
        checkOutput("rst_drop",  32'(ofrm_drop),   0);

        irst_n = 1'b1;
        repeat (260) tick();
        checkOutput("wait_busy",  32'(obusy),       1);
        checkOutput("wait_ready", 32'(ohist_ready), 0);

        // Table-driven single-bin frames.
        for (int v = 0; v < 4; v++) begin
            if (v > 0) rearm();
            for (int i = 0; i < vecs[v].reps; i++) pushSample(vecs[v].grey, 1'b1);
            sendFrame();
            waitReady("vec_ready");
            checkOutput("vec_busy", 32'(obusy), 0);
            readOnce(vecs[v].expBin, d, sd);
            checkOutput("vec_count", 32'(d), 32'(vecs[v].expCount));
            readOnce(vecs[v].zeroBin, d, sd);
            checkOutput("vec_zero", 32'(d), 0);
        end

        // Back-to-back identical bins, then full-rate reads.
        rearm();
        for (int i = 0; i < 10; i++) pushSample(12'hFF0, 1'b1);
        for (int i = 0; i < 5; i++)  pushSample(12'h010, 1'b1);
        sendFrame();
        waitReady("fwd_ready");
        iread_en   = 1'b1;
        iread_addr = 8'd0;
        tick();
        checkOutput("b2b_bin0", 32'(oread_data), 0);
        checkOutput("b2b_val",  32'(oread_val),  1);
        iread_addr = 8'd255;
        tick();
        checkOutput("b2b_bin255", 32'(oread_data), 10);
        iread_addr = 8'd1;
        tick();
        checkOutput("b2b_bin1", 32'(oread_data), 5);
        iread_en = 1'b0;
        tick();
        checkOutput("idle_val",  32'(oread_val),  0);
        checkOutput("idle_hold", 32'(oread_data), 5);

        // Gapped frame; valid samples outside the frame must be ignored.
        rearm();
        igrey     = 12'h123;
        igrey_val = 1'b1;
        ifrm_val  = 1'b0;
        repeat (5) tick();
        igrey_val = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            pushSample((i % 2 == 0) ? 12'h123 : 12'h12F, 1'b1);
            if (i % 3 == 0) pushSample(12'h123, 1'b0);
        end
        sendFrame();
        waitReady("gap_ready");
        readOnce(18, d, sd);
        checkOutput("gap_bin18", 32'(d), 20);

        // Frame arriving while the histogram is held is dropped.
        applyStimulus(1'b1, 1'b1, 12'h123);
        checkOutput("drop_in_done", 32'(ofrm_drop), 1);
        tick();
        checkOutput("drop_pulse_end", 32'(ofrm_drop), 0);
        repeat (3) tick();
        applyStimulus(1'b0, 1'b0, '0);
        readOnce(18, d, sd);
        checkOutput("drop_kept_bin18", 32'(d), 20);

        // Acknowledge wins over a same-cycle read.
        iack       = 1'b1;
        iread_en   = 1'b1;
        iread_addr = 8'd18;
        tick();
        iack     = 1'b0;
        iread_en = 1'b0;
        checkOutput("ack_read_val", 32'(oread_val),   0);
        checkOutput("ack_ready",    32'(ohist_ready), 0);
        checkOutput("ack_busy",     32'(obusy),       1);
        clearModel();

        // Frame starting during the clear sweep is ignored entirely.
        tick();
        tick();
        applyStimulus(1'b1, 1'b1, 12'h800);
        checkOutput("drop_in_clear", 32'(ofrm_drop), 1);
        repeat (300) tick();
        applyStimulus(1'b0, 1'b0, '0);
        repeat (5) tick();
        checkOutput("midframe_busy",  32'(obusy),       1);
        checkOutput("midframe_ready", 32'(ohist_ready), 0);
        for (int i = 0; i < 8; i++) pushSample(12'h800, 1'b1);
        sendFrame();
        waitReady("clr_frame_ready");
        readOnce(128, d, sd);
        checkOutput("clr_frame_bin128", 32'(d), 8);
        readOnce(18, d, sd);
        checkOutput("clr_frame_old18", 32'(d), 0);

        // 20 hits on one bin: narrow counter wraps or saturates.
        rearm();
        for (int i = 0; i < 20; i++) pushSample(12'h030, 1'b1);
        sendFrame();
        waitReady("narrow_ready");
        readOnce(3, d, sd);
        checkOutput("wide_bin3", 32'(d), 20);
`ifdef HIST_SATURATE_EN
        checkOutput("narrow_bin3_sat", 32'(sd), 15);
`else
        checkOutput("narrow_bin3_wrap", 32'(sd), 4);
`endif

        // Reset in the middle of accumulation.
        rearm();
        ifrm_val  = 1'b1;
        igrey_val = 1'b1;
        igrey     = 12'h400;
        repeat (6) tick();
        irst_n    = 1'b0;
        ifrm_val  = 1'b0;
        igrey_val = 1'b0;
        #1;
        checkOutput("mid_rst_data",  32'(oread_data),  0);
        checkOutput("mid_rst_val",   32'(oread_val),   0);
        checkOutput("mid_rst_ready", 32'(ohist_ready), 0);
        checkOutput("mid_rst_busy",  32'(obusy),       1);
        checkOutput("mid_rst_drop",  32'(ofrm_drop),   0);
        clearModel();
        tick();
        irst_n = 1'b1;
        repeat (260) tick();
        for (int i = 0; i < 3; i++) pushSample(12'h400, 1'b1);
        sendFrame();
        waitReady("post_rst_ready");
        readOnce(64, d, sd);
        checkOutput("post_rst_bin64", 32'(d), 3);

        // Randomized frames concentrated on a few bins, full readout vs model.
        for (int f = 0; f < 4; f++) begin
            rearm();
            for (int k = 0; k < 4; k++) hotBins[k] = BB'($urandom);
            len = int'($urandom_range(20, 150));
            for (int i = 0; i < len; i++) begin
                pushSample({hotBins[$urandom_range(0, 3)], 4'($urandom)}, ($urandom_range(0, 3) != 0));
            end
            sendFrame();
            waitReady("rand_ready");
            iread_en = 1'b1;
            for (int b = 0; b < NB; b++) begin
                iread_addr = BB'(b);
                tick();
                checkOutput("rand_bin", 32'(oread_data), expMain(b));
                checkOutput("rand_bin_narrow", 32'(s_oread_data), expSmall(b));
            end
            iread_en = 1'b0;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/grey_histogram.md
# grey_histogram

Per-frame histogram accumulator directly downstream of the greyscale converter. It consumes the registered 12-bit grey sample and its valid strobe, and bins each sample by its top bits into an on-chip count memory over one frame. It then holds the finished histogram for a random-access readout by the display/statistics logic. A clear sweep re-arms it for the next frame.

## Interface
- num_bits_grey, 12, width of incoming grey sample
- bin_bits, 8, log2 of bin count (bin = top bin_bits of sample)
- count_width, 20, width of each bin counter
- iclk  in  1  system clock, all logic on rising edge
- irst_n  in  1  asynchronous, active-low reset
- igrey  in  num_bits_grey  grey sample
- igrey_val  in  1  sample valid
- ifrm_val  in  1  frame valid, aligned to igrey_val (top level registers frame valid once to match converter latency)
- iread_en  in  1  readout request, honoured only in DONE
- iread_addr  in  bin_bits  bin to read
- iack  in  1  one-cycle pulse: readout finished, re-arm
- oread_data  out  count_width  bin count, 1 cycle after accepted iread_en
- oread_val  out  1  oread_data valid strobe
- ohist_ready  out  1  high while a complete histogram is held
- obusy  out  1  high in every state except DONE
- ofrm_drop  out  1  one-cycle pulse when a frame start is ignored

## Operation
- States: CLEAR, WAIT, ACCUM, FLUSH, DONE. Reset state CLEAR.
- CLEAR: address counter 0..2^bin_bits-1 writes zero, one bin per cycle (256 cycles default); after last bin -> WAIT.
- WAIT: on ifrm_val rising edge (ifrm_val=1, registered previous=0) -> ACCUM. A sample valid in that same cycle is accepted.
- ACCUM: sample accepted when igrey_val=1 and ifrm_val=1. ifrm_val=0 -> FLUSH. Samples with ifrm_val=0 are ignored.
- FLUSH: 2 cycles to drain the update pipeline -> DONE.
- DONE: ohist_ready=1; iread_en serviced; iack -> CLEAR. iack takes priority over a same-cycle iread_en; that read is not serviced.
- Frame rising edge seen in CLEAR, FLUSH or DONE: ofrm_drop pulses; that whole frame is ignored. The block never enters ACCUM mid-frame.
- Update pipeline: stage 1 registers bin address and valid, and issues the memory read. Stage 2 adds 1 to the read data and writes it back.
- Read-after-write hazard: if stage-2 write address equals stage-1 address in the same cycle, stage 1 uses the stage-2 write data instead of memory. Back-to-back identical bins must count exactly.
- Counter arithmetic is unsigned count_width. Overflow is set by HIST_SATURATE_EN (Configuration).
- Reset mid-operation: all state abandoned, returns to CLEAR, memory re-zeroed before any accumulation.

## Timing
- Reset values: oread_data=0, oread_val=0, ohist_ready=0, obusy=1, ofrm_drop=0.
- A sample accepted at cycle N is written to memory at edge N+2.
- Last sample of the frame is in memory before DONE is entered.
- Read latency: iread_en at cycle N -> oread_data/oread_val at N+1. Full-rate back-to-back reads are supported. oread_val is 0 otherwise; oread_data holds its last value.
- ohist_ready rises on DONE entry and falls the cycle after iack.
- Min re-arm: iack -> WAIT after 2^bin_bits + 1 cycles.

## Configuration
- HIST_SATURATE_EN defined: a bin at all-ones stays at all-ones on further hits.
- HIST_SATURATE_EN undefined: bin counters wrap modulo 2^count_width.

## Test plan
- Reset release, wait 256 cycles, 4x4 frame of igrey=12'h000, read bin 0 -> 16, bin 1 -> 0, ohist_ready=1.
- Frame with 10 consecutive igrey=12'hFF0 then 5 of 12'h010 (forwarding stress) -> bin 255 = 10, bin 1 = 5.
- Frame alternating 12'h123 / 12'h12F / gaps of igrey_val=0 (20 valids) -> bin 18 = 20; samples with ifrm_val=0 not counted.
- Second frame starts while in DONE -> ofrm_drop pulse, counts unchanged. iack, frame of 8 x 12'h800 -> bin 128 = 8, old bins 0.
- count_width=4, 20 hits on bin 3 -> 15 with HIST_SATURATE_EN, 4 without.
- irst_n asserted mid-ACCUM -> outputs at reset values, obusy=1. Next full frame counts only its own samples.
